// File: rtl/freq_smoother.sv
// freq_smoother: clamps raw pitch estimates, averages them over a 2^AVG_LOG2
// window and presents a frame-stable frequency to the ball sprite stage.
// Sustained silence forces DEFAULT_FREQ until voiced samples return.
module freq_smoother #(
   parameter int FREQ_WIDTH     = 16,
   parameter int AVG_LOG2       = 3,
   parameter int FREQ_MIN       = 80,
   parameter int FREQ_MAX       = 2047,
   parameter int SILENCE_FRAMES = 30,
   parameter int DEFAULT_FREQ   = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  sample_valid_in,
   input  logic [FREQ_WIDTH-1:0] sample_freq_in,
   input  logic                  sample_voiced_in,
   input  logic                  new_frame_in,
   output logic [FREQ_WIDTH-1:0] freq_out,
   output logic                  freq_valid_out,
   output logic                  silent_out
);

   localparam int N      = 1 << AVG_LOG2;
   localparam int SUM_W  = FREQ_WIDTH + AVG_LOG2;
   localparam int FILL_W = AVG_LOG2 + 1;
   localparam int SIL_W  = $clog2(SILENCE_FRAMES + 1);

   typedef enum logic [1:0] {
      SILENT,
      FILLING,
      TRACKING
   } state_t;

   state_t                state;
   logic [FREQ_WIDTH-1:0] buffer [N];
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      new_sum;
   logic [AVG_LOG2-1:0]   wp;
   logic [FILL_W-1:0]     fill_cnt;
   logic [FILL_W-1:0]     fill_next;
   logic [SIL_W-1:0]      sil_cnt;
   logic [FREQ_WIDTH-1:0] avg_q;
   logic [FREQ_WIDTH-1:0] clamped;
   logic                  accepted;
   logic                  go_silent;

   assign accepted  = sample_valid_in && sample_voiced_in;
   assign new_sum   = sum - SUM_W'(buffer[wp]) + SUM_W'(clamped);
   assign fill_next = fill_cnt + FILL_W'(1);

   // The frame that pushes the silence count to its limit drops us into SILENT;
   // an accepted sample on that same edge resets the count instead.
   assign go_silent = (state != SILENT) && new_frame_in && !accepted &&
                      (sil_cnt == SIL_W'(SILENCE_FRAMES - 1));

   // Clamp the raw estimate into the playable range.
   always_comb begin
      // NOTE: default assignment first so every path drives clamped; no latch.
      clamped = sample_freq_in;
      if (sample_freq_in < FREQ_WIDTH'(FREQ_MIN)) begin
         clamped = FREQ_WIDTH'(FREQ_MIN);
      end else if (sample_freq_in > FREQ_WIDTH'(FREQ_MAX)) begin
         clamped = FREQ_WIDTH'(FREQ_MAX);
      end
   end

   // Circular window, running sum and per-sample average; flushed on entry to SILENT.
   always_ff @(posedge clk_in or negedge rst_in) begin
      // NOTE: the window is reset along with the rest, because the running sum
      // subtracts the evicted entry and that only works if unused entries are 0.
      if (!rst_in) begin
         for (int i = 0; i < N; i++) begin
            buffer[i] <= '0;
         end
         sum      <= '0;
         wp       <= '0;
         fill_cnt <= '0;
         avg_q    <= '0;
      end else if (go_silent) begin
         for (int i = 0; i < N; i++) begin
            buffer[i] <= '0;
         end
         sum      <= '0;
         wp       <= '0;
         fill_cnt <= '0;
         avg_q    <= '0;
      end else if (accepted) begin
         // NOTE: non-blocking so new_sum and buffer[wp] see pre-edge values.
         sum        <= new_sum;
         buffer[wp] <= clamped;
         wp         <= wp + AVG_LOG2'(1);
         if (fill_cnt != FILL_W'(N)) begin
            fill_cnt <= fill_next;
         end
         if (state == TRACKING) begin
            avg_q <= FREQ_WIDTH'(new_sum >> AVG_LOG2);
         end else begin
            avg_q <= clamped;
         end
      end
   end

   // Mode FSM, silence counter and frame-boundary output latch.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= SILENT;
         sil_cnt        <= '0;
         freq_out       <= FREQ_WIDTH'(DEFAULT_FREQ);
         freq_valid_out <= 1'b0;
         silent_out     <= 1'b1;
      end else begin
         freq_valid_out <= new_frame_in;

         if (go_silent) begin
            state <= SILENT;
         end else if (accepted && (state != TRACKING) && (fill_next == FILL_W'(N))) begin
            state <= TRACKING;
         end else if (accepted && (state == SILENT)) begin
            state <= FILLING;
         end

         if (go_silent || (state == SILENT) || accepted) begin
            sil_cnt <= '0;
         end else if (new_frame_in && (sil_cnt < SIL_W'(SILENCE_FRAMES))) begin
            sil_cnt <= sil_cnt + SIL_W'(1);
         end

         // avg_q here is the pre-edge value, so a colliding sample shows next frame.
         if (new_frame_in) begin
            if (go_silent || (state == SILENT)) begin
               freq_out   <= FREQ_WIDTH'(DEFAULT_FREQ);
               silent_out <= 1'b1;
            end else begin
               freq_out   <= avg_q;
               silent_out <= 1'b0;
            end
         end
      end
   end

endmodule
